// File: rtl/piso_serializer_if.sv
// piso_serializer_if: handshake and data bundle between a word producer /
// chunk consumer (master side) and the piso_serializer (slave side).
// Widths must match the parameters of the piso_serializer it is bound to.
interface piso_serializer_if #(
   parameter int PARALLEL_WIDTH = 72,
   parameter int SHIFT_WIDTH    = 24,
   parameter int CNT_WIDTH      = 2
);

   // Parallel input side
   logic                      mode;
   logic [PARALLEL_WIDTH-1:0] parallel_in;
   logic                      parallel_in_vld;
   logic                      parallel_in_rdy;

   // Serial output side
   logic [SHIFT_WIDTH-1:0]    serial_out;
   logic                      serial_out_vld;
   logic                      serial_out_rdy;
   logic                      serial_out_last;
   logic [CNT_WIDTH-1:0]      chunk_index;

   // Status
   logic                      busy;

   // Producer of words / consumer of chunks
   modport master (
      output mode,
      output parallel_in,
      output parallel_in_vld,
      input  parallel_in_rdy,
      input  serial_out,
      input  serial_out_vld,
      output serial_out_rdy,
      input  serial_out_last,
      input  chunk_index,
      input  busy
   );

   // The serializer itself
   modport slave (
      input  mode,
      input  parallel_in,
      input  parallel_in_vld,
      output parallel_in_rdy,
      output serial_out,
      output serial_out_vld,
      input  serial_out_rdy,
      output serial_out_last,
      output chunk_index,
      output busy
   );

endinterface : piso_serializer_if

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out block with a two-entry buffer
// (active shift register + holding register) so that consecutive words
// stream out as SHIFT_WIDTH chunks without bubbles.
//
// Per-word mode, latched with the word: 1 = emit every chunk, 0 = emit a
// single truncated beat (the first chunk in emission order, flagged last).
//
// Build option: define PISO_MSB_FIRST_EN to emit chunks from the most
// significant one down; otherwise chunk 0 (LSBs) goes first. chunk_index
// always counts 0..NUM_CHUNK-1 in emission order.
module piso_serializer #(
   parameter int PARALLEL_WIDTH = 72,
   parameter int SHIFT_WIDTH    = 24,
   parameter int CNT_WIDTH      = 2
) (
   input  logic             clk,
   input  logic             reset,
   piso_serializer_if.slave bus
);

   localparam int NUM_CHUNK = PARALLEL_WIDTH / SHIFT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_CHUNK - 1);

   // Elaboration-time parameter sanity checks
   if ((PARALLEL_WIDTH % SHIFT_WIDTH) != 0) begin : g_bad_width
      $error("piso_serializer: PARALLEL_WIDTH must be a multiple of SHIFT_WIDTH");
   end
   if ((1 << CNT_WIDTH) < NUM_CHUNK) begin : g_bad_cnt
      $error("piso_serializer: CNT_WIDTH too small for NUM_CHUNK");
   end

   typedef enum logic {
      S_IDLE  = 1'b0,   // shift register empty
      S_SHIFT = 1'b1    // shift register holds a word being emitted
   } state_e;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e                    state_q;
   logic [PARALLEL_WIDTH-1:0] shift_word_q;   // remaining chunks, next one at the output end
   logic                      shift_mode_q;   // mode latched with the active word
   logic [CNT_WIDTH-1:0]      chunk_idx_q;
   logic                      last_q;         // current chunk is the word's final one
   logic [PARALLEL_WIDTH-1:0] hold_word_q;
   logic                      hold_mode_q;
   logic                      hold_full_q;

   // ---------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------
   logic in_fire;       // word accepted this cycle
   logic out_fire;      // chunk consumed this cycle
   logic word_done;     // final chunk of the active word consumed
   logic in_to_shift;   // accepted word goes straight into the shift register
   logic in_to_hold;    // accepted word parks in the holding register
   logic take_hold;     // holding register moves into the shift register

   assign in_fire     = bus.parallel_in_vld && bus.parallel_in_rdy;
   assign out_fire    = (state_q == S_SHIFT) && bus.serial_out_rdy;
   assign word_done   = out_fire && last_q;
   assign take_hold   = word_done && hold_full_q;
   assign in_to_shift = in_fire && ((state_q == S_IDLE) || (word_done && !hold_full_q));
   assign in_to_hold  = in_fire && !in_to_shift;

   // ---------------------------------------------------------------------
   // Next-value datapath
   // ---------------------------------------------------------------------
   logic [PARALLEL_WIDTH-1:0] load_word_d;
   logic                      load_mode_d;
   logic                      load_last_d;
   logic [PARALLEL_WIDTH-1:0] adv_word_d;
   logic [CNT_WIDTH-1:0]      adv_idx_d;
   logic                      adv_last_d;
   logic                      hold_full_d;

   // Compute the values loaded on a new word and on a chunk advance
   always_comb begin
      // A full holding register always has priority over the input port:
      // it carries the older word. When hold is empty the input is the source.
      load_word_d = hold_full_q ? hold_word_q : bus.parallel_in;
      load_mode_d = hold_full_q ? hold_mode_q : bus.mode;
      load_last_d = !load_mode_d || (NUM_CHUNK == 1);

`ifdef PISO_MSB_FIRST_EN
      adv_word_d  = shift_word_q << SHIFT_WIDTH;
`else
      adv_word_d  = shift_word_q >> SHIFT_WIDTH;
`endif
      adv_idx_d   = chunk_idx_q + CNT_WIDTH'(1);
      adv_last_d  = !shift_mode_q || (adv_idx_d == LAST_IDX);

      // The holding register fills on an accepted word that cannot go
      // straight to the shift register, and empties when it is promoted.
      if (in_to_hold) begin
         hold_full_d = 1'b1;
      end else if (take_hold) begin
         hold_full_d = 1'b0;
      end else begin
         hold_full_d = hold_full_q;
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------
   // Sequence words through the shift register and track chunk position
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q      <= S_IDLE;
         shift_word_q <= '0;
         shift_mode_q <= 1'b0;
         chunk_idx_q  <= '0;
         last_q       <= 1'b0;
         hold_full_q  <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         case (state_q)
            S_IDLE: begin
               if (in_to_shift) begin
                  shift_word_q <= load_word_d;
                  shift_mode_q <= load_mode_d;
                  chunk_idx_q  <= '0;
                  last_q       <= load_last_d;
                  state_q      <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Without a consumed chunk everything holds: backpressure
               // keeps the output chunk, index and last flag stable.
               if (out_fire) begin
                  if (!last_q) begin
                     shift_word_q <= adv_word_d;
                     chunk_idx_q  <= adv_idx_d;
                     last_q       <= adv_last_d;
                  end else if (hold_full_q || in_to_shift) begin
                     // Next word follows with no bubble
                     shift_word_q <= load_word_d;
                     shift_mode_q <= load_mode_d;
                     chunk_idx_q  <= '0;
                     last_q       <= load_last_d;
                  end else begin
                     chunk_idx_q  <= '0;
                     last_q       <= 1'b0;
                     state_q      <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Capture a parked word and its mode into the holding register
   always_ff @(posedge clk) begin
      // NOTE: the holding data is not reset; hold_full_q qualifies it, so
      // leaving it out of reset saves a reset net on a wide register.
      if (in_to_hold) begin
         hold_word_q <= bus.parallel_in;
         hold_mode_q <= bus.mode;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // Ready depends only on registered hold occupancy, never on the output
   // side. It is also held low while reset is asserted so the reset cycle
   // itself cannot accept a word that the reset would then discard.
   assign bus.parallel_in_rdy = !reset && !hold_full_q;

`ifdef PISO_MSB_FIRST_EN
   assign bus.serial_out      = shift_word_q[PARALLEL_WIDTH-1 -: SHIFT_WIDTH];
`else
   assign bus.serial_out      = shift_word_q[SHIFT_WIDTH-1:0];
`endif
   assign bus.serial_out_vld  = (state_q == S_SHIFT);
   assign bus.serial_out_last = last_q;
   assign bus.chunk_index     = chunk_idx_q;
   assign bus.busy            = (state_q == S_SHIFT) || hold_full_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer. Expected chunks
// are pushed when a word is accepted and compared as chunks are consumed.
// Honours PISO_MSB_FIRST_EN for the expected chunk order.
module tb_piso_serializer;

   localparam int PW  = 72;
   localparam int SW  = 24;
   localparam int CW  = 2;
   localparam int NCH = PW / SW;

   typedef struct {
      logic [SW-1:0] data;
      logic          last;
      logic [CW-1:0] idx;
   } beat_t;

   logic  clk;
   logic  reset;
   beat_t exp_q[$];
   int    total;
   int    bad;
   int    beats;

   piso_serializer_if #(.PARALLEL_WIDTH(PW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

   piso_serializer #(
      .PARALLEL_WIDTH (PW),
      .SHIFT_WIDTH    (SW),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected chunk sequence of one accepted word
   function automatic void push_word(input logic [PW-1:0] w, input logic m);
      int    n;
      int    pos;
      beat_t b;
      n = m ? NCH : 1;
      for (int k = 0; k < n; k++) begin
`ifdef PISO_MSB_FIRST_EN
         pos = NCH - 1 - k;
`else
         pos = k;
`endif
         b.data = w[pos*SW +: SW];
         b.last = (k == n - 1);
         b.idx  = CW'(k);
         exp_q.push_back(b);
      end
   endfunction

   // Consumer-side scoreboard: every consumed chunk must match the model
   always @(negedge clk) begin
      if (!reset && bus.serial_out_vld && bus.serial_out_rdy) begin
         beats++;
         if (exp_q.size() == 0) begin
            check("extra_beat", PW'(exp_q.size()), PW'(1));
         end else begin
            beat_t b;
            b = exp_q.pop_front();
            check("beat_data", PW'(bus.serial_out), PW'(b.data));
            check("beat_last", PW'(bus.serial_out_last), PW'(b.last));
            check("beat_idx", PW'(bus.chunk_index), PW'(b.idx));
         end
      end
   end

   // Offer a word until accepted; returns just after the accepting edge
   task automatic send_word(input logic [PW-1:0] w, input logic m);
      bit done;
      done = 1'b0;
      bus.parallel_in     = w;
      bus.mode            = m;
      bus.parallel_in_vld = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (bus.parallel_in_rdy) begin
            push_word(w, m);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", PW'(bus.parallel_in_rdy), PW'(1));
      bus.parallel_in_vld = 1'b0;
      bus.mode            = ~m;   // later mode changes must not affect the accepted word
   endtask

   task automatic wait_idle(input string tag);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 200 && !idle; i++) begin
         @(negedge clk);
         idle = !bus.busy && !bus.serial_out_vld;
         if (!idle) begin
            @(posedge clk);
            #1;
         end
      end
      check(tag, PW'(idle), PW'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [PW-1:0] w;
      logic [95:0]   r;
      int            b0;
      bit            rnd_done;

      total = 0;
      bad   = 0;
      beats = 0;
      reset = 1'b1;
      bus.mode            = 1'b0;
      bus.parallel_in     = '0;
      bus.parallel_in_vld = 1'b0;
      bus.serial_out_rdy  = 1'b1;

      // ---- reset values ----
      @(posedge clk);
      @(negedge clk);
      check("rst_rdy", PW'(bus.parallel_in_rdy), PW'(0));
      check("rst_vld", PW'(bus.serial_out_vld), PW'(0));
      check("rst_busy", PW'(bus.busy), PW'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_rdy", PW'(bus.parallel_in_rdy), PW'(1));
      check("post_rst_out", PW'(bus.serial_out), PW'(0));
      check("post_rst_last", PW'(bus.serial_out_last), PW'(0));
      check("post_rst_idx", PW'(bus.chunk_index), PW'(0));
      @(posedge clk);
      #1;

      // ---- single word: latency and drain ----
      send_word(72'h333333_222222_111111, 1'b1);
      @(negedge clk);
      check("lat_vld", PW'(bus.serial_out_vld), PW'(1));
      check("lat_idx", PW'(bus.chunk_index), PW'(0));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("drain_vld", PW'(bus.serial_out_vld), PW'(0));
      wait_idle("idle_single");

      // ---- back-to-back words: no bubbles, rdy drops while hold is full ----
      send_word(72'hA2A2A2_A1A1A1_A0A0A0, 1'b1);
      send_word(72'hB2B2B2_B1B1B1_B0B0B0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("b2b_vld", PW'(bus.serial_out_vld), PW'(1));
         if (i < 3) check("b2b_rdy", PW'(bus.parallel_in_rdy), PW'(i >= 2));
         @(posedge clk);
         #1;
      end
      wait_idle("idle_b2b");

      // ---- backpressure on chunk 1, third word stalls ----
      send_word(72'h333333_222222_111111, 1'b1);
      @(posedge clk);
      #1;
      bus.serial_out_rdy = 1'b0;
      send_word(72'h666666_555555_444444, 1'b1);
      bus.parallel_in     = 72'h999999_888888_777777;
      bus.mode            = 1'b1;
      bus.parallel_in_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_data", PW'(bus.serial_out), PW'(24'h222222));
         check("bp_idx", PW'(bus.chunk_index), PW'(1));
         check("bp_rdy", PW'(bus.parallel_in_rdy), PW'(0));
         @(posedge clk);
         #1;
      end
      bus.serial_out_rdy = 1'b1;
      send_word(72'h999999_888888_777777, 1'b1);
      wait_idle("idle_bp");

      // ---- mode 0 then mode 1 ----
      b0 = beats;
      send_word(72'hAAAAAA_BBBBBB_CCCCCC, 1'b0);
      send_word(72'hAAAAAA_BBBBBB_CCCCCC, 1'b1);
      wait_idle("idle_mode");
      check("mode_beats", PW'(beats - b0), PW'(4));

      // ---- reset mid-word ----
      send_word(72'hF2F2F2_F1F1F1_F0F0F0, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_vld", PW'(bus.serial_out_vld), PW'(0));
      check("mid_rst_busy", PW'(bus.busy), PW'(0));
      check("mid_rst_idx", PW'(bus.chunk_index), PW'(0));
      repeat (3) begin
         @(negedge clk);
         check("no_partial", PW'(bus.serial_out_vld), PW'(0));
      end
      @(posedge clk);
      #1;
      send_word(72'hE2E2E2_E1E1E1_E0E0E0, 1'b1);
      wait_idle("idle_after_rst");

      // ---- random words, random modes, random backpressure ----
      rnd_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 12; n++) begin
               r = {$urandom, $urandom, $urandom};
               w = r[PW-1:0];
               send_word(w, 1'($urandom_range(0, 1)));
            end
            rnd_done = 1'b1;
         end
         begin
            for (int c = 0; c < 3000 && !rnd_done; c++) begin
               @(posedge clk);
               #2;
               bus.serial_out_rdy = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.serial_out_rdy = 1'b1;
      wait_idle("idle_random");

      check("queue_empty", PW'(exp_q.size()), PW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_piso_serializer
